// File: rtl/controller_pipe.sv
// Control unit for the 3-stage RV32IM core: EX-stage ALU decode, WB control register, mul stall sequencer, GPIO CSR decode.
// Latency: alusrc/aluop/stall combinational in EX; writeback controls registered, 1 clk after the accepting EX cycle.
// Backpressure: stall_EX holds the PC/IF-EX register during multi-cycle multiplies; WB takes a bubble whenever EX is stalled or invalid.
//
// Ports: clk, rst_n (async active-low); EX inputs valid_EX, opcode_EX, funct3_EX, funct7_EX, csr_EX;
//        EX outputs alusrc_EX, aluop_EX, stall_EX; WB outputs regwrite_WB, regsel_WB, gpio_we_WB, illegal_WB.
// Build option: CTRL_ILLEGAL_TRAP_EN makes illegal_WB sticky and freezes all writeback until reset.
module controller_pipe #(
    parameter int          ALUOP_W       = 4,
    parameter int          MUL_CYCLES    = 3,
    parameter int          N_GPIO        = 2,
    parameter logic [11:0] GPIO_CSR_BASE = 12'hF02
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_EX,
    input  logic [6:0]         opcode_EX,
    input  logic [2:0]         funct3_EX,
    input  logic [6:0]         funct7_EX,
    input  logic [11:0]        csr_EX,
    output logic               alusrc_EX,
    output logic [ALUOP_W-1:0] aluop_EX,
    output logic               stall_EX,
    output logic               regwrite_WB,
    output logic [1:0]         regsel_WB,
    output logic [N_GPIO-1:0]  gpio_we_WB,
    output logic               illegal_WB
);
    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [3:0] ALU_AND   = 4'h0;
    localparam logic [3:0] ALU_OR    = 4'h1;
    localparam logic [3:0] ALU_XOR   = 4'h2;
    localparam logic [3:0] ALU_ADD   = 4'h3;
    localparam logic [3:0] ALU_SUB   = 4'h4;
    localparam logic [3:0] ALU_MUL   = 4'h5;
    localparam logic [3:0] ALU_MULH  = 4'h6;
    localparam logic [3:0] ALU_MULHU = 4'h7;
    localparam logic [3:0] ALU_SLL   = 4'h8;
    localparam logic [3:0] ALU_SRL   = 4'h9;
    localparam logic [3:0] ALU_SRA   = 4'hA;
    localparam logic [3:0] ALU_SLT   = 4'hC;
    localparam logic [3:0] ALU_SLTU  = 4'hD;

    localparam logic [1:0] SEL_CSR = 2'b00;
    localparam logic [1:0] SEL_LUI = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic              dec_alusrc;
    logic [3:0]        dec_aluop;
    logic              dec_rw;
    logic [1:0]        dec_sel;
    logic [N_GPIO-1:0] dec_gpio;
    logic              dec_ill;
    logic              dec_mul;
    logic [N_GPIO-1:0] csr_hit;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;

    // One compare per GPIO CSR; at most one bit can be set.
    always_comb begin
        csr_hit = '0;
        for (int k = 0; k < N_GPIO; k++) begin
            csr_hit[k] = (csr_EX == GPIO_CSR_BASE + 12'(k));
        end
    end

    // Instruction decode. dec_ill starts set and each recognised encoding clears it.
    always_comb begin
        dec_alusrc = 1'b0;
        dec_aluop  = ALU_AND;
        dec_rw     = 1'b0;
        dec_sel    = SEL_CSR;
        dec_gpio   = '0;
        dec_ill    = 1'b1;
        dec_mul    = 1'b0;
        case (opcode_EX)
            OPC_OPIMM: begin
                dec_ill    = 1'b0;
                dec_alusrc = 1'b1;
                dec_rw     = 1'b1;
                dec_sel    = SEL_ALU;
                case (funct3_EX)
                    3'b000:  dec_aluop = ALU_ADD;
                    3'b111:  dec_aluop = ALU_AND;
                    3'b110:  dec_aluop = ALU_OR;
                    3'b100:  dec_aluop = ALU_XOR;
                    3'b001:  if (funct7_EX == F7_BASE) dec_aluop = ALU_SLL; else dec_ill = 1'b1;
                    3'b101: begin
                        if (funct7_EX == F7_BASE)     dec_aluop = ALU_SRL;
                        else if (funct7_EX == F7_ALT) dec_aluop = ALU_SRA;
                        else                          dec_ill   = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec_ill = 1'b0;
                dec_rw  = 1'b1;
                dec_sel = SEL_ALU;
                case (funct7_EX)
                    F7_BASE: begin
                        case (funct3_EX)
                            3'b000:  dec_aluop = ALU_ADD;
                            3'b001:  dec_aluop = ALU_SLL;
                            3'b010:  dec_aluop = ALU_SLT;
                            3'b011:  dec_aluop = ALU_SLTU;
                            3'b100:  dec_aluop = ALU_XOR;
                            3'b101:  dec_aluop = ALU_SRL;
                            3'b110:  dec_aluop = ALU_OR;
                            default: dec_aluop = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3_EX)
                            3'b000:  dec_aluop = ALU_SUB;
                            3'b101:  dec_aluop = ALU_SRA;
                            default: dec_ill   = 1'b1;
                        endcase
                    end
                    F7_MUL: begin
                        dec_mul = 1'b1;
                        case (funct3_EX)
                            3'b000:  dec_aluop = ALU_MUL;
                            3'b001:  dec_aluop = ALU_MULH;
                            3'b011:  dec_aluop = ALU_MULHU;
                            default: dec_ill   = 1'b1;
                        endcase
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_ill = 1'b0;
                dec_rw  = 1'b1;
                dec_sel = SEL_LUI;
            end
            OPC_SYS: begin
                // Only csrrw is supported; GPIO CSRs are write-only side effects, others read back.
                if (funct3_EX == 3'b001) begin
                    dec_ill = 1'b0;
                    if (|csr_hit) begin
                        dec_gpio = csr_hit;
                    end else begin
                        dec_rw  = 1'b1;
                        dec_sel = SEL_CSR;
                    end
                end
            end
            default: ;
        endcase
        // Illegal encodings drive every control to its inactive value.
        if (dec_ill) begin
            dec_alusrc = 1'b0;
            dec_aluop  = ALU_AND;
            dec_rw     = 1'b0;
            dec_sel    = SEL_CSR;
            dec_gpio   = '0;
            dec_mul    = 1'b0;
        end
    end

    assign alusrc_EX = dec_alusrc;
    assign aluop_EX  = ALUOP_W'(dec_aluop);

    // Mul sequencer. The first stall comes from IDLE; BUSY counts the remaining
    // cycles and releases the stall on the last one so WB captures the result.
    // Stall is suppressed under reset so the core can refetch cleanly.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_EX  = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_EX && dec_mul && (MUL_CYCLES > 1) && rst_n) begin
                    stall_EX  = 1'b1;
                    state_nxt = S_BUSY;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (!valid_EX) begin
                    // Flush: abandon the multiply, no stall this cycle.
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall_EX = 1'b1;
                    cnt_nxt  = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign accept = valid_EX && !stall_EX;

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky trap: once an illegal instruction reaches WB, all writeback stays off until reset.
    logic trap_nxt;
    assign trap_nxt = illegal_WB | (accept & dec_ill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_WB <= 1'b0;
            regsel_WB   <= 2'b00;
            gpio_we_WB  <= '0;
            illegal_WB  <= 1'b0;
        end else begin
            regwrite_WB <= accept & dec_rw & ~trap_nxt;
            regsel_WB   <= accept ? dec_sel : 2'b00;
            gpio_we_WB  <= (accept && !trap_nxt) ? dec_gpio : '0;
            illegal_WB  <= trap_nxt;
        end
    end
`else
    // Illegal instructions retire as NOPs (decode already cleared their enables); illegal_WB is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_WB <= 1'b0;
            regsel_WB   <= 2'b00;
            gpio_we_WB  <= '0;
            illegal_WB  <= 1'b0;
        end else begin
            regwrite_WB <= accept & dec_rw;
            regsel_WB   <= accept ? dec_sel : 2'b00;
            gpio_we_WB  <= accept ? dec_gpio : '0;
            illegal_WB  <= accept & dec_ill;
        end
    end
`endif

endmodule

// File: tb/tb_controller_pipe.sv
// Self-checking bench for controller_pipe: decode table, mul stall sequencing, flush, illegal handling, async reset.
// Latency: WB expectations are queued when EX is driven and compared one clock later.
// Backpressure: expected stall pattern is generated from the multiply cycle count.
module tb_controller_pipe;
    localparam int AW = 4;
    localparam int MC = 3;
    localparam int NG = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_EX;
    logic [6:0]    opcode_EX;
    logic [2:0]    funct3_EX;
    logic [6:0]    funct7_EX;
    logic [11:0]   csr_EX;
    logic          alusrc_EX;
    logic [AW-1:0] aluop_EX;
    logic          stall_EX;
    logic          regwrite_WB;
    logic [1:0]    regsel_WB;
    logic [NG-1:0] gpio_we_WB;
    logic          illegal_WB;

    controller_pipe #(
        .ALUOP_W(AW), .MUL_CYCLES(MC), .N_GPIO(NG), .GPIO_CSR_BASE(12'hF02)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX),
        .opcode_EX(opcode_EX), .funct3_EX(funct3_EX), .funct7_EX(funct7_EX), .csr_EX(csr_EX),
        .alusrc_EX(alusrc_EX), .aluop_EX(aluop_EX), .stall_EX(stall_EX),
        .regwrite_WB(regwrite_WB), .regsel_WB(regsel_WB), .gpio_we_WB(gpio_we_WB), .illegal_WB(illegal_WB)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic [1:0]    sel;
        logic [NG-1:0] gpio;
        logic          ill;
    } wb_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [11:0] csr;
        logic       alusrc;
        logic [3:0] aluop;
        logic       rw;
        logic [1:0] sel;
        logic [NG-1:0] gpio;
        logic       ill;
    } vec_t;

    wb_t  sbq[$];
    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;
    logic sticky = 1'b0;

    function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [11:0] csr, input logic alusrc,
                                input logic [3:0] aluop, input logic rw, input logic [1:0] sel,
                                input logic [NG-1:0] gpio, input logic ill);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.csr = csr;
        v.alusrc = alusrc; v.aluop = aluop; v.rw = rw; v.sel = sel; v.gpio = gpio; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected WB contents for one EX cycle, including the illegal-trap policy of this build.
    task automatic push_wb(input logic acc, input logic rw, input logic [1:0] sel,
                           input logic [NG-1:0] gpio, input logic ill);
        wb_t e;
        e.sel = acc ? sel : 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (acc && ill) sticky = 1'b1;
        e.rw   = acc & rw & !sticky;
        e.gpio = (acc && !sticky) ? gpio : '0;
        e.ill  = sticky;
`else
        e.rw   = acc & rw;
        e.gpio = acc ? gpio : '0;
        e.ill  = acc & ill;
`endif
        sbq.push_back(e);
    endtask

    task automatic tick_and_check(input string name);
        wb_t e;
        wb_t got;
        @(posedge clk);
        #1;
        got.rw = regwrite_WB; got.sel = regsel_WB; got.gpio = gpio_we_WB; got.ill = illegal_WB;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL %s WB: no expected entry, got %b", name, got);
        end else begin
            e = sbq.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL %s WB {rw,sel,gpio,ill}: got %b expected %b", name, got, e);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] csr);
        @(negedge clk);
        valid_EX = v; opcode_EX = op; funct3_EX = f3; funct7_EX = f7; csr_EX = csr;
    endtask

    task automatic run_vec(input vec_t v);
        drive(1'b1, v.op, v.f3, v.f7, v.csr);
        #1;
        chk({v.name, " alusrc"}, 32'(alusrc_EX), 32'(v.alusrc));
        chk({v.name, " aluop"}, 32'(aluop_EX), 32'(v.aluop));
        chk({v.name, " stall"}, 32'(stall_EX), 32'd0);
        push_wb(1'b1, v.rw, v.sel, v.gpio, v.ill);
        tick_and_check(v.name);
    endtask

    // One multiply held in EX for its full duration; WB only captures on the last cycle.
    task automatic run_mul(input string name, input logic [2:0] f3, input logic [3:0] aluop);
        for (int i = 0; i < MC; i++) begin
            drive(1'b1, 7'b0110011, f3, 7'b0000001, 12'h000);
            #1;
            chk({name, " stall"}, 32'(stall_EX), 32'(i < MC - 1));
            chk({name, " aluop"}, 32'(aluop_EX), 32'(aluop));
            push_wb(!(i < MC - 1), 1'b1, 2'b10, '0, 1'b0);
            tick_and_check(name);
        end
    endtask

    task automatic check_wb_zero(input string name);
        chk({name, " regwrite"}, 32'(regwrite_WB), 32'd0);
        chk({name, " regsel"}, 32'(regsel_WB), 32'd0);
        chk({name, " gpio_we"}, 32'(gpio_we_WB), 32'd0);
        chk({name, " illegal"}, 32'(illegal_WB), 32'd0);
        chk({name, " stall"}, 32'(stall_EX), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t add_v;
        add_v = mk("add", 7'b0110011, 3'b000, 7'h00, 12'h0, 1'b0, 4'h3, 1'b1, 2'b10, 2'b00, 1'b0);

        tbl.push_back(mk("addi",  7'b0010011, 3'b000, 7'h00, 12'h0, 1'b1, 4'h3, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("andi",  7'b0010011, 3'b111, 7'h00, 12'h0, 1'b1, 4'h0, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("ori",   7'b0010011, 3'b110, 7'h00, 12'h0, 1'b1, 4'h1, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("xori",  7'b0010011, 3'b100, 7'h00, 12'h0, 1'b1, 4'h2, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("slli",  7'b0010011, 3'b001, 7'h00, 12'h0, 1'b1, 4'h8, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("srli",  7'b0010011, 3'b101, 7'h00, 12'h0, 1'b1, 4'h9, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("srai",  7'b0010011, 3'b101, 7'h20, 12'h0, 1'b1, 4'hA, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(add_v);
        tbl.push_back(mk("sub",   7'b0110011, 3'b000, 7'h20, 12'h0, 1'b0, 4'h4, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("sll",   7'b0110011, 3'b001, 7'h00, 12'h0, 1'b0, 4'h8, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("slt",   7'b0110011, 3'b010, 7'h00, 12'h0, 1'b0, 4'hC, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("sltu",  7'b0110011, 3'b011, 7'h00, 12'h0, 1'b0, 4'hD, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("xor",   7'b0110011, 3'b100, 7'h00, 12'h0, 1'b0, 4'h2, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("srl",   7'b0110011, 3'b101, 7'h00, 12'h0, 1'b0, 4'h9, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("sra",   7'b0110011, 3'b101, 7'h20, 12'h0, 1'b0, 4'hA, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("or",    7'b0110011, 3'b110, 7'h00, 12'h0, 1'b0, 4'h1, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("and",   7'b0110011, 3'b111, 7'h00, 12'h0, 1'b0, 4'h0, 1'b1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("lui",   7'b0110111, 3'b000, 7'h00, 12'h0, 1'b0, 4'h0, 1'b1, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("gpio0", 7'b1110011, 3'b001, 7'h00, 12'hF02, 1'b0, 4'h0, 1'b0, 2'b00, 2'b01, 1'b0));
        tbl.push_back(mk("gpio1", 7'b1110011, 3'b001, 7'h00, 12'hF03, 1'b0, 4'h0, 1'b0, 2'b00, 2'b10, 1'b0));
        tbl.push_back(mk("csrF00", 7'b1110011, 3'b001, 7'h00, 12'hF00, 1'b0, 4'h0, 1'b1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("csrF04", 7'b1110011, 3'b001, 7'h00, 12'hF04, 1'b0, 4'h0, 1'b1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("slti_ill", 7'b0010011, 3'b010, 7'h00, 12'h0, 1'b0, 4'h0, 1'b0, 2'b00, 2'b00, 1'b1));
        tbl.push_back(mk("div_ill",  7'b0110011, 3'b100, 7'h01, 12'h0, 1'b0, 4'h0, 1'b0, 2'b00, 2'b00, 1'b1));
        tbl.push_back(mk("csrrs_ill", 7'b1110011, 3'b010, 7'h00, 12'hF02, 1'b0, 4'h0, 1'b0, 2'b00, 2'b00, 1'b1));

        // Reset state
        rst_n = 1'b0; valid_EX = 1'b0; opcode_EX = '0; funct3_EX = '0; funct7_EX = '0; csr_EX = '0;
        #12;
        check_wb_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Multiplies, including back-to-back
        run_mul("mul",   3'b000, 4'h5);
        run_mul("mulh",  3'b001, 4'h6);
        run_mul("mulhu", 3'b011, 4'h7);

        // Flush on the second stall cycle, then a 1-clk add
        drive(1'b1, 7'b0110011, 3'b000, 7'h01, 12'h0);
        #1;
        chk("flush first stall", 32'(stall_EX), 32'd1);
        push_wb(1'b0, 1'b0, 2'b00, '0, 1'b0);
        tick_and_check("flush c0");
        drive(1'b0, 7'b0110011, 3'b000, 7'h01, 12'h0);
        #1;
        chk("flush stall", 32'(stall_EX), 32'd0);
        push_wb(1'b0, 1'b0, 2'b00, '0, 1'b0);
        tick_and_check("flush bubble");
        run_vec(add_v);

        // Decode table (illegal entries last)
        foreach (tbl[i]) run_vec(tbl[i]);

        // Illegal opcode followed by adds
        drive(1'b1, 7'b1111111, 3'b000, 7'h00, 12'h0);
        #1;
        chk("op7F aluop", 32'(aluop_EX), 32'd0);
        push_wb(1'b1, 1'b0, 2'b00, '0, 1'b1);
        tick_and_check("op7F");
        run_vec(add_v);
        run_vec(add_v);

        // Async reset right after a capture
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_wb_zero("reset after add");
        sbq.delete();
        sticky = 1'b0;
        valid_EX = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[0]);

        // Async reset mid-BUSY with the mul still presented
        drive(1'b1, 7'b0110011, 3'b000, 7'h01, 12'h0);
        #1;
        chk("busy entry stall", 32'(stall_EX), 32'd1);
        push_wb(1'b0, 1'b0, 2'b00, '0, 1'b0);
        tick_and_check("busy entry");
        #2;
        rst_n = 1'b0;
        #1;
        check_wb_zero("reset mid busy");
        sbq.delete();
        sticky = 1'b0;
        @(negedge clk);
        valid_EX = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);

        // The lost mul is refetched and pays the full count again
        run_mul("mul after reset", 3'b000, 4'h5);
        run_vec(add_v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
